cov_add_sym: RTL and testbench
==============================

# cov_add_sym

Element-wise fixed-point matrix adder/subtractor with saturation and optional symmetrization. It sits directly downstream of the matrix multiplier in the EKF covariance path. It consumes the N×N product (e.g. F·P·Fᵀ or K·H·P) and combines it with a second matrix, forming P_pred = F·P·Fᵀ + Q or P_upd = P − K·H·P. The result is then optionally forced symmetric to suppress round-off drift.

## Interface
Parameters:
- N, 4, matrix dimension (N×N); legal range 2..8
- DATA_WIDTH, FRAC_BITS, FP_MAX_POS, FP_MIN_NEG, FP_ZERO: taken from fp_arith_pkg (not overridable)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin operation; sampled only in IDLE
- sub  input  1  0: C = A + B, 1: C = A − B; sampled with start
- done  output  1  one-cycle completion pulse, registered
- busy  output  1  high from the edge after start acceptance until the done edge
- overflow  output  1  sticky saturation flag for the current operation; valid when done=1
- matrix_a  input  [N][N]×DATA_WIDTH signed  operand A (multiplier product); held stable while busy
- matrix_b  input  [N][N]×DATA_WIDTH signed  operand B (Q or K·H·P); held stable while busy
- matrix_p  output  [N][N]×DATA_WIDTH signed  result registers

## Operation
- Reset values: done=0, busy=0, overflow=0, all matrix_p=FP_ZERO, state=IDLE, indices=0.
- **IDLE**:
  - done<=0.
  - If start: latch sub, overflow<=0, i=j=0, busy<=1, go to ADD.
- **ADD**: one element per cycle, row-major (i outer, j inner).
  - sum = sign-extended (DATA_WIDTH+1)-bit A[i][j] ± B[i][j].
  - If sum > FP_MAX_POS, write FP_MAX_POS and set overflow<=1.
  - If sum < FP_MIN_NEG, write FP_MIN_NEG and set overflow<=1.
  - Otherwise write sum[DATA_WIDTH-1:0] to matrix_p[i][j].
  - After element (N−1,N−1): go to SYM if COV_SYMMETRIZE_EN is defined, else DONE.
- **SYM**: one upper-triangle pair per cycle, order i=0..N−2, j=i+1..N−1.
  - avg = (p[i][j] + p[j][i]) >>> 1, computed at DATA_WIDTH+1 bits with arithmetic shift (floor toward −∞).
  - Write avg to both p[i][j] and p[j][i]; it cannot overflow.
  - Diagonal is untouched.
  - After pair (N−2,N−1): go to DONE.
- **DONE**: done<=1, busy<=0, go to IDLE. done is therefore high for exactly one cycle.
- matrix_p holds its value until the next start; it is partially updated during an operation.
- start while busy: ignored, no queuing.
- start asserted in the same cycle that done is high: state is IDLE, so it is accepted normally.

## Timing
- Edge 0 is the edge that samples start in IDLE; busy is high after edge 0.
- ADD writes occur at edges 1..N·N.
- Without symmetrization: done is high after edge N·N+1 (N=4: edge 17).
- With symmetrization: K = N(N−1)/2 SYM writes at edges N·N+1..N·N+K; done is high after edge N·N+K+1 (N=4: edge 23).
- busy falls on the same edge done rises.
- rst_n asserted mid-operation (any state): all outputs return to reset values immediately. A subsequent start runs a full, clean operation.

## Configuration
- COV_SYMMETRIZE_EN defined:
  - SYM state is compiled in.
  - Output is exactly symmetric.
  - Latency is N·N + N(N−1)/2 + 1.
- Not defined:
  - SYM state and pair counters are absent.
  - Output is the raw saturated element-wise result.
  - Latency is N·N + 1.

## Test plan
- Add, N=4, macro off: A=identity (1.0), B all 0.25, sub=0 -> diagonal 1.25, off-diagonal 0.25, overflow=0, done high after edge 17 only.
- Saturation: A[0][0]=FP_MAX_POS, B[0][0]=1 LSB, sub=0 -> p[0][0]=FP_MAX_POS, overflow=1. A[1][1]=FP_MIN_NEG, B[1][1]=1 LSB, sub=1 -> p[1][1]=FP_MIN_NEG. A fresh start clears overflow.
- Subtract: sub=1, A all 2.0, B all 0.5 -> all elements 1.5, overflow=0.
- Symmetrization, macro on, B=0:
  - A[0][1]=0.5, A[1][0]=0.25 -> both 0.375.
  - Raw pair 1 LSB/2 LSB -> both 1 LSB; raw pair −1/−2 LSB -> both −2 LSB.
  - Diagonal unchanged; done high after edge 23.
  - Macro off, same stimulus: asymmetric result preserved.
- Control: start pulsed again during ADD -> ignored, done pulses once. rst_n low at ADD cycle 5 -> matrix_p all 0, busy=0, done=0. The next start completes correctly.

Source files
------------

// File: rtl/fp_arith_pkg.sv
// Shared fixed-point format for the EKF covariance datapath (Q7.8, 16-bit signed).
package fp_arith_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    localparam logic signed [DATA_WIDTH-1:0] FP_MAX_POS = 16'sh7FFF;
    localparam logic signed [DATA_WIDTH-1:0] FP_MIN_NEG = 16'sh8000;
    localparam logic signed [DATA_WIDTH-1:0] FP_ZERO    = 16'sh0000;

endpackage

// File: rtl/cov_add_sym_if.sv
// Handshake and matrix bus between the covariance adder and its controller.
interface cov_add_sym_if
    import fp_arith_pkg::*;
#(
    parameter int N = 4
);

    logic start;
    logic sub;
    logic done;
    logic busy;
    logic overflow;
    logic signed [DATA_WIDTH-1:0] matrix_a [N][N];
    logic signed [DATA_WIDTH-1:0] matrix_b [N][N];
    logic signed [DATA_WIDTH-1:0] matrix_p [N][N];

    modport master (
        output start, sub, matrix_a, matrix_b,
        input  done, busy, overflow, matrix_p
    );

    modport slave (
        input  start, sub, matrix_a, matrix_b,
        output done, busy, overflow, matrix_p
    );

endinterface

// File: rtl/cov_add_sym.sv
// Element-wise saturating N x N add/subtract for the EKF covariance path.
// Define COV_SYMMETRIZE_EN to average each off-diagonal pair after the add pass.
module cov_add_sym
    import fp_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cov_add_sym_if.slave  bus
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
`ifdef COV_SYMMETRIZE_EN
    localparam logic [IW-1:0] LAST_ROW_SYM = IW'(N - 2);
`endif

    localparam logic signed [DATA_WIDTH:0] MAX_W = {FP_MAX_POS[DATA_WIDTH-1], FP_MAX_POS};
    localparam logic signed [DATA_WIDTH:0] MIN_W = {FP_MIN_NEG[DATA_WIDTH-1], FP_MIN_NEG};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
`ifdef COV_SYMMETRIZE_EN
        SYM  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    function automatic logic signed [DATA_WIDTH:0] ext(input logic signed [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

    function automatic logic is_sat(input logic signed [DATA_WIDTH:0] x);
        return (x > MAX_W) || (x < MIN_W);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] x);
        if (x > MAX_W)
            return FP_MAX_POS;
        else if (x < MIN_W)
            return FP_MIN_NEG;
        else
            return x[DATA_WIDTH-1:0];
    endfunction

`ifdef COV_SYMMETRIZE_EN
    // Floor average: the wide sum plus arithmetic shift always fits back in DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] avg2(input logic signed [DATA_WIDTH-1:0] a,
                                                          input logic signed [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] s;
        logic signed [DATA_WIDTH:0] h;
        s = ext(a) + ext(b);
        h = s >>> 1;
        return h[DATA_WIDTH-1:0];
    endfunction
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic            sub_q;
    logic            done_q;
    logic            busy_q;
    logic            ovf_q;
    logic signed [DATA_WIDTH-1:0] p_q [N][N];
    logic signed [DATA_WIDTH:0]   elem_sum;
`ifdef COV_SYMMETRIZE_EN
    logic signed [DATA_WIDTH-1:0] pair_avg;
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        elem_sum = sub_q ? (ext(bus.matrix_a[i_q][j_q]) - ext(bus.matrix_b[i_q][j_q]))
                         : (ext(bus.matrix_a[i_q][j_q]) + ext(bus.matrix_b[i_q][j_q]));
`ifdef COV_SYMMETRIZE_EN
        pair_avg = avg2(p_q[i_q][j_q], p_q[j_q][i_q]);
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ADD;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ADD: begin
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
`ifdef COV_SYMMETRIZE_EN
                        state_d = SYM;
                        i_d     = '0;
                        j_d     = IW'(1);
`else
                        state_d = DONE;
                        i_d     = '0;
`endif
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
`ifdef COV_SYMMETRIZE_EN
            // Walk the strict upper triangle; each row restarts just right of the diagonal.
            SYM: begin
                if (j_q == LAST) begin
                    if (i_q == LAST_ROW_SYM) begin
                        state_d = DONE;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        i_d = i_q + 1'b1;
                        j_d = i_q + IW'(2);
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            p_q     <= '{default: FP_ZERO};
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            done_q  <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sub_q  <= bus.sub;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ADD: begin
                    p_q[i_q][j_q] <= sat(elem_sum);
                    if (is_sat(elem_sum))
                        ovf_q <= 1'b1;
                end
`ifdef COV_SYMMETRIZE_EN
                SYM: begin
                    p_q[i_q][j_q] <= pair_avg;
                    p_q[j_q][i_q] <= pair_avg;
                end
`endif
                DONE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.matrix_p = p_q;

endmodule

// File: tb/tb_cov_add_sym.sv
// Directed bench for cov_add_sym (N=4, Q7.8); expectations follow COV_SYMMETRIZE_EN.
module tb_cov_add_sym;
    import fp_arith_pkg::*;

    localparam int N   = 4;
    localparam int ONE = 1 << FRAC_BITS;
`ifdef COV_SYMMETRIZE_EN
    localparam int LAT    = 23;
    localparam bit SYM_ON = 1'b1;
`else
    localparam int LAT    = 17;
    localparam bit SYM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cov_add_sym_if #(.N(N)) bus ();
    cov_add_sym #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int vectors     = 0;
    int miscompares = 0;
    int lat, pulses;
    logic signed [15:0] exp_p [N][N];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_mat(input string tag);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c), bus.matrix_p[r][c], exp_p[r][c]);
    endtask

    task automatic fill_ab(input int av, input int bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                bus.matrix_a[r][c] = 16'(av);
                bus.matrix_b[r][c] = 16'(bv);
            end
    endtask

    task automatic fill_exp(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_p[r][c] = 16'(v);
    endtask

    task automatic set_identity_quarter();
        fill_ab(0, 64);
        for (int k = 0; k < N; k++) bus.matrix_a[k][k] = 16'(ONE);
        fill_exp(64);
        for (int k = 0; k < N; k++) exp_p[k][k] = 16'sd320;
    endtask

    // Start on edge 0, then watch 40 edges; optionally re-pulse start (with flipped sub) mid-run.
    task automatic run_op(input logic s, input int repulse, output int l, output int np);
        l  = 0;
        np = 0;
        @(negedge clk);
        bus.sub   = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", bus.busy, 1);
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            bus.start = (e == repulse);
            bus.sub   = (e == repulse) ? ~s : s;
            @(posedge clk);
            #1;
            if (bus.done) begin
                np++;
                if (l == 0) begin
                    l = e;
                    chk("busy_at_done", bus.busy, 0);
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.sub   = s;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        fill_ab(0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", bus.done, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ovf", bus.overflow, 0);
        fill_exp(0);
        chk_mat("reset_p");
        @(negedge clk);
        rst_n = 1'b1;

        // Identity + 0.25 everywhere
        set_identity_quarter();
        run_op(1'b0, 0, lat, pulses);
        chk("add_latency", lat, LAT);
        chk("add_pulses", pulses, 1);
        chk("add_ovf", bus.overflow, 0);
        chk_mat("add_p");

        // Positive saturation
        fill_ab(0, 0);
        bus.matrix_a[0][0] = 16'sh7FFF;
        bus.matrix_b[0][0] = 16'sd1;
        run_op(1'b0, 0, lat, pulses);
        fill_exp(0);
        exp_p[0][0] = 16'sh7FFF;
        chk("satpos_ovf", bus.overflow, 1);
        chk_mat("satpos_p");

        // Negative saturation through subtract
        fill_ab(0, 0);
        bus.matrix_a[1][1] = -16'sd32768;
        bus.matrix_b[1][1] = 16'sd1;
        run_op(1'b1, 0, lat, pulses);
        fill_exp(0);
        exp_p[1][1] = -16'sd32768;
        chk("satneg_ovf", bus.overflow, 1);
        chk_mat("satneg_p");

        // Subtract 2.0 - 0.5; fresh start clears the sticky flag
        fill_ab(2 * ONE, 128);
        run_op(1'b1, 0, lat, pulses);
        fill_exp(384);
        chk("sub_ovf", bus.overflow, 0);
        chk("sub_latency", lat, LAT);
        chk_mat("sub_p");

        // Asymmetric pairs with B = 0
        fill_ab(0, 0);
        bus.matrix_a[0][1] = 16'sd128;
        bus.matrix_a[1][0] = 16'sd64;
        bus.matrix_a[0][2] = 16'sd1;
        bus.matrix_a[2][0] = 16'sd2;
        bus.matrix_a[1][3] = -16'sd1;
        bus.matrix_a[3][1] = -16'sd2;
        for (int k = 0; k < N; k++) bus.matrix_a[k][k] = 16'(100 + k);
        run_op(1'b0, 0, lat, pulses);
        fill_exp(0);
        for (int k = 0; k < N; k++) exp_p[k][k] = 16'(100 + k);
        if (SYM_ON) begin
            exp_p[0][1] = 16'sd96; exp_p[1][0] = 16'sd96;
            exp_p[0][2] = 16'sd1;  exp_p[2][0] = 16'sd1;
            exp_p[1][3] = -16'sd2; exp_p[3][1] = -16'sd2;
        end else begin
            exp_p[0][1] = 16'sd128; exp_p[1][0] = 16'sd64;
            exp_p[0][2] = 16'sd1;   exp_p[2][0] = 16'sd2;
            exp_p[1][3] = -16'sd1;  exp_p[3][1] = -16'sd2;
        end
        chk("sym_latency", lat, LAT);
        chk("sym_pulses", pulses, 1);
        chk_mat("sym_p");

        // Start re-pulsed during ADD with sub flipped: must be ignored
        fill_ab(2 * ONE, 128);
        run_op(1'b1, 3, lat, pulses);
        fill_exp(384);
        chk("repulse_latency", lat, LAT);
        chk("repulse_pulses", pulses, 1);
        chk_mat("repulse_p");

        // Asynchronous reset after the fifth ADD write
        set_identity_quarter();
        @(negedge clk);
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ovf", bus.overflow, 0);
        fill_exp(0);
        chk_mat("midrst_p");
        @(negedge clk);
        rst_n = 1'b1;

        set_identity_quarter();
        run_op(1'b0, 0, lat, pulses);
        chk("postrst_latency", lat, LAT);
        chk("postrst_pulses", pulses, 1);
        chk_mat("postrst_p");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
